// File: rtl/rvx10_pkg.sv
// Shared RV32I/RVX10 encoding constants, descriptor types and loader state
// used by the instruction encoder, the decoder and the program loader.
package rvx10_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned REG_W = 5;
   localparam int unsigned IMM_W = 21;
   localparam int unsigned OP_W  = 4;

   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

   localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

   typedef enum logic [2:0] {
      KIND_LW  = 3'd0,
      KIND_SW  = 3'd1,
      KIND_R   = 3'd2,
      KIND_BEQ = 3'd3,
      KIND_I   = 3'd4,
      KIND_JAL = 3'd5,
      KIND_RVX = 3'd6,
      KIND_ILL = 3'd7
   } instr_kind_e;

   // ALU control codes, identical to the decoder's ALU control field
   localparam logic [OP_W-1:0] ALU_ADD  = 4'b0000;
   localparam logic [OP_W-1:0] ALU_SUB  = 4'b0001;
   localparam logic [OP_W-1:0] ALU_AND  = 4'b0010;
   localparam logic [OP_W-1:0] ALU_OR   = 4'b0011;
   localparam logic [OP_W-1:0] ALU_SLT  = 4'b0101;
   localparam logic [OP_W-1:0] ALU_ANDN = 4'b0110;
   localparam logic [OP_W-1:0] ALU_ORN  = 4'b0111;
   localparam logic [OP_W-1:0] ALU_XNOR = 4'b1000;
   localparam logic [OP_W-1:0] ALU_MIN  = 4'b1001;
   localparam logic [OP_W-1:0] ALU_MAX  = 4'b1010;
   localparam logic [OP_W-1:0] ALU_MINU = 4'b1011;
   localparam logic [OP_W-1:0] ALU_MAXU = 4'b1100;
   localparam logic [OP_W-1:0] ALU_ROL  = 4'b1101;
   localparam logic [OP_W-1:0] ALU_ROR  = 4'b1110;
   localparam logic [OP_W-1:0] ALU_ABS  = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } loader_state_e;

   typedef struct packed {
      instr_kind_e      kind;
      logic [OP_W-1:0]  op;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [IMM_W-1:0] imm;
   } instr_desc_t;

   // True when a 21-bit signed immediate fits a 12-bit signed field
   function automatic logic fits_imm12(input logic [IMM_W-1:0] imm);
      return (&imm[IMM_W-1:11]) || !(|imm[IMM_W-1:11]);
   endfunction

   // True when a 21-bit signed immediate fits a 13-bit signed field
   function automatic logic fits_imm13(input logic [IMM_W-1:0] imm);
      return (&imm[IMM_W-1:12]) || !(|imm[IMM_W-1:12]);
   endfunction

endpackage

// File: rtl/rvx10_encode.sv
// Stateless encoder: one decoded descriptor to a 32-bit RV32I/RVX10 word,
// with a flag for descriptors that have no legal encoding (word is then nop).
module rvx10_encode
   import rvx10_pkg::*;
(
   input  instr_desc_t     desc,
   output logic [XLEN-1:0] word,
   output logic            illegal
);

   logic [2:0] alu_f3;
   logic [6:0] alu_f7;
   logic       alu_ok;
   logic [2:0] rvx_f3;
   logic [1:0] rvx_f7;
   logic       rvx_ok;
   logic [4:0] rvx_rs2;
   logic       imm12_ok;
   logic       beq_ok;

   // Base ALU op to funct3/funct7
   always_comb begin
      alu_f3 = 3'b000;
      alu_f7 = 7'b0000000;
      alu_ok = 1'b1;
      case (desc.op)
         ALU_ADD: alu_f3 = 3'b000;
         ALU_SUB: begin
            alu_f3 = 3'b000;
            alu_f7 = 7'b0100000;
         end
         ALU_SLT: alu_f3 = 3'b010;
         ALU_OR:  alu_f3 = 3'b110;
         ALU_AND: alu_f3 = 3'b111;
         default: alu_ok = 1'b0;
      endcase
   end

   // RVX10 op to the two funct7 selector bits and funct3
   always_comb begin
      rvx_f3 = 3'b000;
      rvx_f7 = 2'b00;
      rvx_ok = 1'b1;
      case (desc.op)
         ALU_ANDN: begin rvx_f7 = 2'b00; rvx_f3 = 3'b000; end
         ALU_ORN:  begin rvx_f7 = 2'b00; rvx_f3 = 3'b001; end
         ALU_XNOR: begin rvx_f7 = 2'b00; rvx_f3 = 3'b010; end
         ALU_MIN:  begin rvx_f7 = 2'b01; rvx_f3 = 3'b000; end
         ALU_MAX:  begin rvx_f7 = 2'b01; rvx_f3 = 3'b001; end
         ALU_MINU: begin rvx_f7 = 2'b01; rvx_f3 = 3'b010; end
         ALU_MAXU: begin rvx_f7 = 2'b01; rvx_f3 = 3'b011; end
         ALU_ROL:  begin rvx_f7 = 2'b10; rvx_f3 = 3'b000; end
         ALU_ROR:  begin rvx_f7 = 2'b10; rvx_f3 = 3'b001; end
         ALU_ABS:  begin rvx_f7 = 2'b11; rvx_f3 = 3'b000; end
         default:  rvx_ok = 1'b0;
      endcase
   end

   // abs is unary, so its rs2 field is always zero
   assign rvx_rs2  = (desc.op == ALU_ABS) ? 5'd0 : desc.rs2;
   assign imm12_ok = fits_imm12(desc.imm);
   assign beq_ok   = fits_imm13(desc.imm) && !desc.imm[0];

   always_comb begin
      word    = NOP_WORD;
      illegal = 1'b0;
      case (desc.kind)
         KIND_LW: begin
            if (imm12_ok)
               word = {desc.imm[11:0], desc.rs1, 3'b010, desc.rd, OPC_LOAD};
            else
               illegal = 1'b1;
         end
         KIND_SW: begin
            if (imm12_ok)
               word = {desc.imm[11:5], desc.rs2, desc.rs1, 3'b010,
                       desc.imm[4:0], OPC_STORE};
            else
               illegal = 1'b1;
         end
         KIND_R: begin
            if (alu_ok)
               word = {alu_f7, desc.rs2, desc.rs1, alu_f3, desc.rd, OPC_OP};
            else
               illegal = 1'b1;
         end
         KIND_BEQ: begin
            if (beq_ok)
               word = {desc.imm[12], desc.imm[10:5], desc.rs2, desc.rs1, 3'b000,
                       desc.imm[4:1], desc.imm[11], OPC_BRANCH};
            else
               illegal = 1'b1;
         end
         KIND_I: begin
            if (alu_ok && (desc.op != ALU_SUB) && imm12_ok)
               word = {desc.imm[11:0], desc.rs1, alu_f3, desc.rd, OPC_OP_IMM};
            else
               illegal = 1'b1;
         end
         KIND_JAL: begin
            if (!desc.imm[0])
               word = {desc.imm[20], desc.imm[10:1], desc.imm[11], desc.imm[19:12],
                       desc.rd, OPC_JAL};
            else
               illegal = 1'b1;
         end
         KIND_RVX: begin
            if (rvx_ok)
               word = {5'b00000, rvx_f7, rvx_rs2, desc.rs1, rvx_f3, desc.rd, OPC_CUSTOM0};
            else
               illegal = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_loader.sv
// Program loader: accepts decoded descriptors, encodes them and writes the
// words to consecutive instruction-memory addresses starting at BASE_ADDR.
module instr_loader
   import rvx10_pkg::*;
#(
   parameter int unsigned ADDR_W    = 6,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_kind,
   input  logic [3:0]        in_op,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [20:0]       in_imm,
   input  logic              in_last,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   count
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] TOP_ADDR  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] BASE_PTR  = ADDR_W'(BASE_ADDR);

   loader_state_e     state;
   logic [ADDR_W-1:0] ptr;
   instr_desc_t       desc;
   logic [31:0]       enc_word;
   logic              enc_illegal;
   logic              accept;
   logic              at_top;
   logic              overflow;
   logic              finish;

   assign desc = '{kind: instr_kind_e'(in_kind), op: in_op, rd: in_rd,
                   rs1: in_rs1, rs2: in_rs2, imm: in_imm};

   rvx10_encode u_encode (
      .desc    (desc),
      .word    (enc_word),
      .illegal (enc_illegal)
   );

   // The top word ends the session unless it was the last one anyway
   always_comb begin
      accept   = in_valid && (state == ST_LOAD);
      at_top   = (ptr == TOP_ADDR);
      overflow = accept && at_top && !in_last;
      finish   = accept && (in_last || at_top);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         in_ready <= 1'b0;
         we       <= 1'b0;
         waddr    <= '0;
         wdata    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         count    <= '0;
      end else begin
         we <= accept;
         if (accept) begin
            waddr <= ptr;
            wdata <= enc_word;
            ptr   <= ADDR_W'(ptr + 1'b1);
            count <= (ADDR_W + 1)'(count + 1'b1);
            if (enc_illegal || overflow)
               err <= 1'b1;
         end
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state    <= ST_LOAD;
                  ptr      <= BASE_PTR;
                  count    <= '0;
                  err      <= 1'b0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
                  done     <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (finish) begin
                  state    <= ST_DONE;
                  in_ready <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end
            end
            default: begin
               state    <= ST_IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/instr_loader.md
# instr_loader

Sequential instruction encoder and instruction-memory writer, the inverse of the pipelined control unit's decode path. It accepts a stream of decoded instruction descriptors (class, ALU operation code, register indices, immediate) over a valid/ready handshake. Each descriptor is encoded into a 32-bit RV32I or RVX10 machine word and written to consecutive instruction-memory words. It is used by the bench and by the boot path to load programs into the core's instruction memory.

## Interface
- ADDR_W, 6: instruction-memory word-address width; DEPTH = 2**ADDR_W words.
- BASE_ADDR, 0: first word address written in each session; must be < DEPTH.

- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a load session; honoured only in IDLE or DONE
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid & in_ready at rising edge
- in_kind  in  3  instruction class: 0 lw, 1 sw, 2 R-type, 3 beq, 4 I-type ALU, 5 jal, 6 RVX10; 7 illegal
- in_op  in  4  ALU operation code, same 4-bit encoding as the core's ALU control
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  21  signed immediate (byte offset for beq/jal)
- in_last  in  1  final descriptor of the session
- we  out  1  instruction-memory write enable, one-cycle pulse per word
- waddr  out  ADDR_W  word address
- wdata  out  32  encoded instruction
- busy  out  1  state == LOAD
- done  out  1  state == DONE
- err  out  1  sticky; set on an illegal descriptor or overflow, cleared by start
- count  out  ADDR_W+1  words accepted this session

## Operation
- States: IDLE → (start) LOAD → (in_last accepted, or overflow) DONE → (start) LOAD.
- start: ptr ← BASE_ADDR, count ← 0, err ← 0. start is ignored in LOAD.
- in_ready = (state == LOAD).
- On accept: encoded word is registered to wdata, ptr to waddr, and we ← 1. Then ptr ← ptr+1 (mod DEPTH) and count ← count+1.
- Overflow: the beat that writes address DEPTH−1 with in_last = 0 sets err and moves to DONE. No wraparound write occurs.
- Encoding:
  - lw: opcode 0000011, f3 010, I-format.
  - sw: opcode 0100011, f3 010, S-format, rs2 = data register.
  - R-type: opcode 0110011; in_op 0000 add f3 000 f7 0; 0001 sub f3 000 f7 0100000; 0101 slt f3 010; 0011 or f3 110; 0010 and f3 111.
  - I-type: opcode 0010011, same f3 table; sub is illegal.
  - beq: opcode 1100011, f3 000, B-format.
  - jal: opcode 1101111, J-format.
  - RVX10: opcode 0001011, funct7 = {00000, f7_2b}, mapped as in_op → f7_2b/f3:
    - 0110 → 00/000, 0111 → 00/001, 1000 → 00/010
    - 1001 → 01/000, 1010 → 01/001, 1011 → 01/010, 1100 → 01/011
    - 1101 → 10/000, 1110 → 10/001
    - 1111 → 11/000, with the rs2 field forced to 0
- Illegal descriptor: any of the following sets err and writes 0x00000013 (nop); the session continues.
  - in_kind 7, or an unmapped in_op.
  - I/S immediate outside [−2048, 2047].
  - beq immediate outside [−4096, 4094] or odd.
  - jal immediate odd. The 21-bit immediate range is inherent.

## Timing
- Reset (reset = 0, asynchronous): state IDLE; in_ready, we, busy, done, err = 0; waddr, wdata, count = 0. An in-flight write is dropped.
- Latency: a descriptor accepted at edge N gives we = 1 with waddr/wdata valid during cycle N+1.
- Throughput: one word per cycle. Back-to-back accepts produce back-to-back we pulses.
- After the last accept, busy falls and done rises at the same edge. The final we pulse coincides with the first done cycle.
- start and in_valid in the same IDLE cycle: the beat is not accepted, since in_ready = 0 until the next cycle.
- count and err update at the accept edge.

## Structure
- Shared package rvx10_pkg holds:
  - the opcode constants (LOAD, STORE, OP, BRANCH, OP_IMM, JAL, CUSTOM0);
  - the instr_kind_e enum;
  - the 4-bit ALU op localparams, shared with the decoder;
  - the loader state enum.
- One combinational sub-module, rvx10_encode: descriptor → {word, illegal}. It has no state.
- instr_loader holds the FSM, pointer, counters and output registers.

## Test plan
- Session: start, then add x3,x1,x2 (kind 2, op 0000), lw x5,8(x0), jal x0,8 (in_last) → writes at addresses 0, 1, 2 with data 0x002081B3, 0x00802283, 0x0080006F; done = 1, count = 3, err = 0.
- RVX10 min x4,x1,x2 (kind 6, op 1001) → 0x0220820B. abs x4,x1 with in_rs2 = 7 → rs2 field = 0, giving 0x0600820B.
- I-type imm = 4096 → err = 1, wdata = 0x00000013; the session continues and the next word is written to the following address.
- ADDR_W = 2, five beats without in_last → four writes to addresses 0..3, err = 1, done = 1, fifth beat never accepted.
- Assert reset mid-session during a we cycle → outputs zero immediately, state IDLE; after release, start, then one beat → writes to BASE_ADDR.
- Continuous in_valid over 8 beats → 8 consecutive we cycles, waddr incrementing by 1 each cycle.
